// File: rtl/brg_cgra_link_reset_seq_if.sv
// brg_cgra_link_reset_seq_if: start request and reset/status outputs of the link reset sequencer
interface brg_cgra_link_reset_seq_if;
  logic       start_i;
  logic       async_uplink_reset_o;
  logic       async_downlink_reset_o;
  logic       async_downstream_reset_o;
  logic       async_token_reset_o;
  logic       core_reset_o;
  logic       busy_o;
  logic       done_o;
  logic [2:0] state_o;
  modport master (
    output start_i,
    input  async_uplink_reset_o, async_downlink_reset_o, async_downstream_reset_o,
    input  async_token_reset_o, core_reset_o, busy_o, done_o, state_o
  );
  modport slave (
    input  start_i,
    output async_uplink_reset_o, async_downlink_reset_o, async_downstream_reset_o,
    output async_token_reset_o, core_reset_o, busy_o, done_o, state_o
  );
endinterface

// File: rtl/brg_cgra_link_reset_seq.sv
// brg_cgra_link_reset_seq: timed reset sequencer for the CGRA pod SDR links and core
module brg_cgra_link_reset_seq #(
  parameter int hold_cycles_p  = 16,
  parameter int token_cycles_p = 8,
  parameter bit auto_start_p   = 1'b1
) (
  input logic clk_i,
  input logic reset_n_i,
  brg_cgra_link_reset_seq_if.slave link
);
  localparam int max_c = hold_cycles_p > token_cycles_p ? hold_cycles_p : token_cycles_p;
  localparam int cw = $clog2(max_c + 1);
  localparam logic [2:0] s_idle      = 3'd0;
  localparam logic [2:0] s_reset_all = 3'd1;
  localparam logic [2:0] s_token_hi  = 3'd2;
  localparam logic [2:0] s_up_rel    = 3'd4;
  localparam logic [2:0] s_down_rel  = 3'd5;
  localparam logic [2:0] s_ds_rel    = 3'd6;
  localparam logic [2:0] s_done      = 3'd7;
  logic [2:0] state_r, state_n;
  logic [cw-1:0] cnt_r, cnt_n;
  logic busy, go, adv;
  always_comb begin
    busy = state_r != s_idle && state_r != s_done;
    go = (state_r == s_idle && (link.start_i || auto_start_p)) || (state_r == s_done && link.start_i);
    adv = busy && cnt_r == '0;
    state_n = go ? s_reset_all : adv ? state_r + 3'd1 : state_r;
    cnt_n = (go || adv) ? (state_n == s_token_hi ? cw'(token_cycles_p - 1) : cw'(hold_cycles_p - 1))
          : busy ? cnt_r - cw'(1) : cnt_r;
  end
  // outputs are decoded from the next state so each one is a plain flop
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r                       <= s_idle;
      cnt_r                         <= '0;
      link.async_uplink_reset_o     <= 1'b1;
      link.async_downlink_reset_o   <= 1'b1;
      link.async_downstream_reset_o <= 1'b1;
      link.async_token_reset_o      <= 1'b0;
      link.core_reset_o             <= 1'b1;
      link.busy_o                   <= 1'b0;
      link.done_o                   <= 1'b0;
    end else begin
      state_r                       <= state_n;
      cnt_r                         <= cnt_n;
      link.async_uplink_reset_o     <= state_n < s_up_rel;
      link.async_downlink_reset_o   <= state_n < s_down_rel;
      link.async_downstream_reset_o <= state_n < s_ds_rel;
      link.async_token_reset_o      <= state_n == s_token_hi;
      link.core_reset_o             <= state_n != s_done;
      link.busy_o                   <= state_n != s_idle && state_n != s_done;
      link.done_o                   <= state_n == s_done;
    end
  end
  assign link.state_o = state_r;
endmodule

// File: tb/tb_brg_cgra_link_reset_seq.sv
// tb_brg_cgra_link_reset_seq: scoreboard bench for three sequencer configurations sharing one stimulus
module tb_brg_cgra_link_reset_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic start = 1'b0;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always #5 clk = ~clk;

  brg_cgra_link_reset_seq_if lk0 ();
  brg_cgra_link_reset_seq_if lk1 ();
  brg_cgra_link_reset_seq_if lk2 ();
  assign lk0.start_i = start;
  assign lk1.start_i = start;
  assign lk2.start_i = start;

  brg_cgra_link_reset_seq #(.hold_cycles_p(4), .token_cycles_p(2), .auto_start_p(1'b0)) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .link(lk0));
  brg_cgra_link_reset_seq #(.hold_cycles_p(4), .token_cycles_p(2), .auto_start_p(1'b1)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .link(lk1));
  brg_cgra_link_reset_seq #(.hold_cycles_p(1), .token_cycles_p(1), .auto_start_p(1'b1)) dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .link(lk2));

  // {state, uplink, downlink, downstream, token, core, busy, done}
  logic [9:0] obs [3];
  assign obs[0] = {lk0.state_o, lk0.async_uplink_reset_o, lk0.async_downlink_reset_o,
                   lk0.async_downstream_reset_o, lk0.async_token_reset_o, lk0.core_reset_o,
                   lk0.busy_o, lk0.done_o};
  assign obs[1] = {lk1.state_o, lk1.async_uplink_reset_o, lk1.async_downlink_reset_o,
                   lk1.async_downstream_reset_o, lk1.async_token_reset_o, lk1.core_reset_o,
                   lk1.busy_o, lk1.done_o};
  assign obs[2] = {lk2.state_o, lk2.async_uplink_reset_o, lk2.async_downlink_reset_o,
                   lk2.async_downstream_reset_o, lk2.async_token_reset_o, lk2.core_reset_o,
                   lk2.busy_o, lk2.done_o};

  // model: idle flag plus cycles elapsed since the sequence (re)entered RESET_ALL
  int hs [3] = '{4, 4, 1};
  int ts [3] = '{2, 2, 1};
  bit as [3] = '{1'b0, 1'b1, 1'b1};
  bit idle [3] = '{1'b1, 1'b1, 1'b1};
  int k [3] = '{0, 0, 0};
  logic [9:0] q [3][$];

  function automatic logic [9:0] expv(int i);
    int h, t, kk, st;
    h = hs[i]; t = ts[i]; kk = k[i];
    if (idle[i]) return 10'b000_111_0_1_0_0;
    st = kk < h ? 1 : kk < h + t ? 2 : kk >= 5*h + t ? 7 : 3 + (kk - h - t) / h;
    return {st[2:0], kk < 2*h + t, kk < 3*h + t, kk < 4*h + t, kk >= h && kk < h + t,
            kk < 5*h + t, kk < 5*h + t, kk >= 5*h + t};
  endfunction

  task automatic tick(input bit st, input bit rn);
    @(negedge clk);
    start = st;
    if (!rn && rst_n) begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
        idle[i] = 1'b1;
        q[i].push_back(expv(i));
      end
    end else rst_n = rn;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) idle[i] = 1'b1;
      else if (idle[i]) begin
        if (st || as[i]) begin idle[i] = 1'b0; k[i] = 0; end
      end else if (k[i] >= 5*hs[i] + ts[i] && st) k[i] = 0;
      else if (k[i] < 5*hs[i] + ts[i]) k[i]++;
      q[i].push_back(expv(i));
    end
  endtask

  initial begin : monitor
    logic [9:0] e, a;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (q[i].size() != 0) begin
          e = q[i].pop_front();
          a = obs[i];
          compared++;
          if (a !== e) begin
            mismatched++;
            $display("FAIL outputs dut%0d cyc %0d: got %b expected %b", i, cyc, a, e);
          end
          compared++;
          if ((a[3] && !(a[6] && a[5] && a[4])) || (!a[5] && a[6]) || (!a[4] && a[5]) ||
              (!a[2] && a[4]) || (a[0] && (a[6] || a[5] || a[4] || a[3]))) begin
            mismatched++;
            $display("FAIL order dut%0d cyc %0d: got %b", i, cyc, a);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) tick(1'b0, 1'b0);
    repeat (20) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    repeat (30) tick(1'b0, 1'b1);
    repeat (31) tick(1'b1, 1'b1);
    repeat (5) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    repeat (13) tick(1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0);
    repeat (30) tick(1'b0, 1'b1);
    for (int n = 0; n < 10000; n++)
      tick($urandom_range(0, 19) == 0, $urandom_range(0, 199) != 0);
    tick(1'b0, 1'b1);
    #3;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (q[i].size() != 0) begin
        mismatched++;
        $display("FAIL drain dut%0d: %0d left, expected 0", i, q[i].size());
      end
    end
    compared++;
    if (compared < 1000) begin
      mismatched++;
      $display("FAIL coverage: %0d comparisons, expected at least 1000", compared);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
